// File: rtl/bram_patch_collect_pkg.sv
// Shared widths and FSM encoding for the BRAM patch collector.
package bram_patch_collect_pkg;
    localparam int DATA_W    = 480;
    localparam int PATCH_NUM = 8;
    localparam int CH_W      = 10;
    localparam int ADDR_W    = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_WAIT_BUF,
        S_DRAIN
    } state_t;
endpackage

// File: rtl/bram_patch_collect_if.sv
// Patch-reader fetch bus plus the patch output stream.
interface bram_patch_collect_if #(
    parameter int DATA_W    = bram_patch_collect_pkg::DATA_W,
    parameter int PATCH_NUM = bram_patch_collect_pkg::PATCH_NUM,
    parameter int CH_W      = bram_patch_collect_pkg::CH_W
);
    import bram_patch_collect_pkg::*;

    logic                        rd_data_bottom;
    logic [ADDR_W-1:0]           rd_data_bram_patch_ith_offset;
    logic                        rd_data_bram_patch_valid;
    logic                        rd_data_bram_patch_last;
    logic [DATA_W-1:0]           bram_doutb;
    logic [PATCH_NUM*DATA_W-1:0] patch_data;
    logic [CH_W-1:0]             patch_ch;
    logic                        patch_valid;
    logic                        patch_ready;

    modport master (
        output rd_data_bottom, rd_data_bram_patch_ith_offset,
        input  rd_data_bram_patch_valid, rd_data_bram_patch_last,
        input  bram_doutb,
        output patch_data, patch_ch, patch_valid,
        input  patch_ready
    );

    modport slave (
        input  rd_data_bottom, rd_data_bram_patch_ith_offset,
        output rd_data_bram_patch_valid, rd_data_bram_patch_last,
        output bram_doutb,
        input  patch_data, patch_ch, patch_valid,
        output patch_ready
    );
endinterface

// File: rtl/bram_patch_collect_patch_buf.sv
// Patch storage: one or two word buffers with full flags and fill-order pointers.
module patch_buf #(
    parameter int DATA_W    = bram_patch_collect_pkg::DATA_W,
    parameter int PATCH_NUM = bram_patch_collect_pkg::PATCH_NUM,
    parameter int CH_W      = bram_patch_collect_pkg::CH_W,
    parameter int NBUF      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [$clog2(PATCH_NUM)-1:0] wr_idx_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         commit_i,
    input  logic [CH_W-1:0]              wr_ch_i,
    input  logic                         pop_i,
    output logic [1:0]                   cnt_o,
    output logic                         rd_valid_o,
    output logic [PATCH_NUM*DATA_W-1:0]  rd_data_o,
    output logic [CH_W-1:0]              rd_ch_o
);
    localparam bit TWO = (NBUF == 2);

    // Slot 1 stays idle in the single-buffer build and is trimmed away.
    logic [DATA_W-1:0] mem_q [2][PATCH_NUM];
    logic [CH_W-1:0]   ch_q [2];
    logic [1:0]        full_q, full_d;
    logic              wr_q, rd_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_q][wr_idx_i] <= wr_data_i;
    end

    always_comb begin
        full_d = full_q;
        if (pop_i)    full_d[rd_q] = 1'b0;
        if (commit_i) full_d[wr_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            ch_q[0] <= '0;
            ch_q[1] <= '0;
        end else begin
            full_q <= full_d;
            if (commit_i) begin
                ch_q[wr_q] <= wr_ch_i;
                wr_q       <= TWO & ~wr_q;
            end
            if (pop_i) rd_q <= TWO & ~rd_q;
        end
    end

    assign cnt_o      = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign rd_valid_o = full_q[rd_q];
    assign rd_ch_o    = ch_q[rd_q];

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < PATCH_NUM; k++)
            rd_data_o[k*DATA_W +: DATA_W] = mem_q[rd_q][k];
    end
endmodule

// File: rtl/bram_patch_collect.sv
// Collects PATCH_NUM BRAM words per channel into patches for a consumer.
// Define BRAM_PATCH_PINGPONG_EN for two buffers (fetch overlaps consumption).
module bram_patch_collect #(
    parameter int DATA_W    = bram_patch_collect_pkg::DATA_W,
    parameter int PATCH_NUM = bram_patch_collect_pkg::PATCH_NUM,
    parameter int CH_W      = bram_patch_collect_pkg::CH_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CH_W-1:0]      ch_num,
    output logic                 done,
    output logic                 err_last,
    bram_patch_collect_if.master bus
);
    import bram_patch_collect_pkg::*;

`ifdef BRAM_PATCH_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif
    localparam int         BW     = $clog2(PATCH_NUM);
    localparam logic [1:0] NBUF_C = 2'(NBUF);

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        ch_idx_q, ch_idx_d;
    logic [CH_W-1:0]        ch_num_q, ch_num_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   wr_en, commit, pop, last_ch, pv;
    logic [1:0]             cnt, cnt_after;
    logic [ADDR_W+CH_W-1:0] off_wide;

    assign pop       = pv && bus.patch_ready;
    assign wr_en     = (state_q == S_FILL) && bus.rd_data_bram_patch_valid;
    assign commit    = wr_en && (beat_q == BW'(PATCH_NUM - 1));
    assign last_ch   = (ch_idx_q == ch_num_q - CH_W'(1));
    assign cnt_after = cnt + 2'd1 - {1'b0, pop};
    assign off_wide  = {{ADDR_W{1'b0}}, ch_idx_q} << BW;

    assign bus.rd_data_bram_patch_ith_offset = off_wide[ADDR_W-1:0];
    assign bus.rd_data_bottom = (state_q == S_REQ);
    assign bus.patch_valid    = pv;
    assign done               = done_q;
    assign err_last           = err_q;

    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        ch_num_d = ch_num_q;
        beat_d   = beat_q;
        done_d   = 1'b0;
        err_d    = err_q;
        if (wr_en && bus.rd_data_bram_patch_last && !commit) err_d = 1'b1;
        if (wr_en) beat_d = commit ? '0 : beat_q + BW'(1);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ch_num_d = ch_num;
                    ch_idx_d = '0;
                    beat_d   = '0;
                    if (ch_num == '0) done_d = 1'b1;
                    else state_d = S_REQ;
                end
            end
            S_REQ: state_d = S_FILL;
            S_FILL: begin
                // A same-cycle pop frees a slot for the next fetch.
                if (commit) begin
                    ch_idx_d = ch_idx_q + CH_W'(1);
                    if (last_ch) state_d = S_DRAIN;
                    else if (cnt_after < NBUF_C) state_d = S_REQ;
                    else state_d = S_WAIT_BUF;
                end
            end
            S_WAIT_BUF: if (pop) state_d = S_REQ;
            S_DRAIN: begin
                if (pop && cnt == 2'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ch_idx_q <= '0;
            ch_num_q <= '0;
            beat_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            ch_num_q <= ch_num_d;
            beat_q   <= beat_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    patch_buf #(
        .DATA_W(DATA_W), .PATCH_NUM(PATCH_NUM), .CH_W(CH_W), .NBUF(NBUF)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_idx_i   (beat_q),
        .wr_data_i  (bus.bram_doutb),
        .commit_i   (commit),
        .wr_ch_i    (ch_idx_q),
        .pop_i      (pop),
        .cnt_o      (cnt),
        .rd_valid_o (pv),
        .rd_data_o  (bus.patch_data),
        .rd_ch_o    (bus.patch_ch)
    );
endmodule

// File: tb/tb_bram_patch_collect.sv
// Self-checking bench for bram_patch_collect (single or ping-pong build).
module tb_bram_patch_collect;
    localparam int DW = 480;
    localparam int PN = 8;
    localparam int CW = 10;
`ifdef BRAM_PATCH_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef struct {
        logic [PN*DW-1:0] data;
        logic [CW-1:0]    ch;
        int               avail;
    } patch_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] ch_num = '0;
    logic          done, err_last;
    int            checks = 0;
    int            failures = 0;
    bit            err_exp = 0;

    bram_patch_collect_if #(.DATA_W(DW), .PATCH_NUM(PN), .CH_W(CW)) bus ();

    bram_patch_collect #(.DATA_W(DW), .PATCH_NUM(PN), .CH_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ch_num   (ch_num),
        .done     (done),
        .err_last (err_last),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_patch(input logic [PN*DW-1:0] obs, input logic [PN*DW-1:0] exp);
        int k;
        checks++;
        assert (obs === exp) else begin
            failures++;
            k = 0;
            for (int i = PN - 1; i >= 0; i--)
                if (obs[i*DW +: DW] !== exp[i*DW +: DW]) k = i;
            $error("FAIL patch_data word %0d observed=%h expected=%h",
                   k, obs[k*DW +: DW], exp[k*DW +: DW]);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < (DW + 31) / 32; i++) w = (w << 32) | DW'($urandom());
        return w;
    endfunction

    task automatic chk_reset_outputs(input string sfx);
        chk({"rst_bottom", sfx}, bus.rd_data_bottom, 0);
        chk({"rst_offset", sfx}, bus.rd_data_bram_patch_ith_offset, 0);
        chk({"rst_pvalid", sfx}, bus.patch_valid, 0);
        chk({"rst_pch", sfx}, bus.patch_ch, 0);
        chk({"rst_done", sfx}, done, 0);
        chk({"rst_err", sfx}, err_last, 0);
    endtask

    // Model: patch k of a pass is channel k at offset k*PN, holding the
    // words the reader sent for request k; at most NB patches outstanding.
    task automatic run_pass(input int n, input int rdy_pct, input int gap_pct,
                            input int err_beat, input bit seq, input int hold);
        patch_t        q[$];
        patch_t        cur;
        logic [DW-1:0] w;
        int  req_cnt = 0, xfer = 0, beat = 0, it = 0;
        bit  active = 0, new_req = 0, done_due, err_pend = 0, fin = 0, vexp, rdy;
        start    = 1'b1;
        ch_num   = CW'(n);
        done_due = (n == 0);
        while (!fin) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (err_pend) begin
                err_exp  = 1;
                err_pend = 0;
            end
            vexp = 0;
            if (q.size() > 0) vexp = (q[0].avail <= it);
            chk("done", done, done_due);
            chk("err_last", err_last, err_exp);
            chk("patch_valid", bus.patch_valid, vexp);
            if (bus.patch_valid && q.size() > 0) begin
                chk("patch_ch", bus.patch_ch, q[0].ch);
                chk_patch(bus.patch_data, q[0].data);
            end
            if (bus.rd_data_bottom) begin
                chk("offset", bus.rd_data_bram_patch_ith_offset, 13'(req_cnt * PN));
                chk("req_room", (q.size() < NB) && !active && (req_cnt < n), 1);
                req_cnt++;
                new_req = 1;
            end
            if (hold > 0 && it == hold) begin
                chk("hold_reqs", req_cnt, NB);
                chk("hold_valid", bus.patch_valid, 1);
            end
            if (done_due) fin = 1;
            else if (it >= 3000) begin
                checks++;
                failures++;
                $error("FAIL timeout observed=%0d patches expected=%0d", xfer, n);
                fin = 1;
            end
            if (!fin) begin
                done_due = 0;
                rdy = (it >= hold) && ($urandom_range(99) < rdy_pct);
                bus.patch_ready = rdy;
                if (rdy && bus.patch_valid && q.size() > 0) begin
                    void'(q.pop_front());
                    xfer++;
                    if (xfer == n) done_due = 1;
                end
                if (active && $urandom_range(99) >= gap_pct) begin
                    w = seq ? DW'(beat + 1) : rnd_word();
                    cur.data[beat*DW +: DW] = w;
                    bus.rd_data_bram_patch_valid = 1'b1;
                    bus.bram_doutb = w;
                    bus.rd_data_bram_patch_last = (beat == PN - 1) || (beat == err_beat);
                    if (beat == err_beat && err_beat != PN - 1) err_pend = 1;
                    if (beat == PN - 1) begin
                        cur.ch    = CW'(req_cnt - 1);
                        cur.avail = it + 1;
                        q.push_back(cur);
                        active = 0;
                    end
                    beat++;
                end else begin
                    // Stray beats while no fetch is open must be dropped.
                    bus.rd_data_bram_patch_valid = !active && ($urandom_range(3) == 0);
                    bus.bram_doutb = rnd_word();
                    bus.rd_data_bram_patch_last = 1'($urandom_range(1));
                end
                if (new_req) begin
                    active  = 1;
                    beat    = 0;
                    new_req = 0;
                end
                if ($urandom_range(9) == 0) begin
                    start  = 1'b1;
                    ch_num = CW'($urandom_range(0, 15));
                end
                it++;
            end
        end
        bus.patch_ready = 1'b0;
        bus.rd_data_bram_patch_valid = 1'b0;
        bus.rd_data_bram_patch_last = 1'b0;
        chk("req_count", req_cnt, n);
        chk("left_patches", q.size(), 0);
    endtask

    initial begin
        bus.rd_data_bram_patch_valid = 1'b0;
        bus.rd_data_bram_patch_last  = 1'b0;
        bus.bram_doutb  = '0;
        bus.patch_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("_init");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_pass(3, 100, 0, -1, 0, 0);
        run_pass(1, 100, 0, -1, 1, 0);
        run_pass(0, 100, 0, -1, 0, 0);
        run_pass(2, 100, 0, -1, 0, 20);
        for (int p = 0; p < 6; p++)
            run_pass($urandom_range(1, 5), $urandom_range(20, 100),
                     $urandom_range(0, 60), -1, 0, 0);
        run_pass(1, 100, 0, 5, 0, 0);
        run_pass(2, 50, 30, -1, 0, 0);

        start  = 1'b1;
        ch_num = CW'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("abort_req", bus.rd_data_bottom, 1);
        for (int i = 0; i < 3; i++) begin
            bus.rd_data_bram_patch_valid = 1'b1;
            bus.bram_doutb = rnd_word();
            @(posedge clk);
            #1;
        end
        chk("abort_err_held", err_last, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("_mid");
        bus.rd_data_bram_patch_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        err_exp = 0;
        @(posedge clk);
        #1;
        run_pass(1, 100, 0, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
